// File: rtl/imem_loader.sv
// Instruction memory program loader: packs a byte stream into 128-bit blocks
// and writes them with the WRITE/ADDRESS/BUSYWAIT block protocol, holding the
// CPU in reset until the whole program has been written.
module imem_loader #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_BLOCK,
  input  logic [ADDR_W-1:0] LENGTH,
  input  logic              BYTE_VALID,
  input  logic [7:0]        BYTE_DATA,
  output logic              BYTE_READY,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [127:0]      MEM_WRITEDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned REM_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [REM_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [3:0]       byte_cnt;
  logic [REM_W-1:0] remaining;
  logic [TMR_W-1:0] idle_timer;
  logic             byte_accept;

  // BYTE_READY is only high in COLLECT, so this is the accept strobe
  assign byte_accept = BYTE_VALID && BYTE_READY;

  // Loader FSM with registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      remaining     <= '0;
      idle_timer    <= '0;
      BYTE_READY    <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      CPU_HOLD      <= 1'b1;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (START) begin
            state       <= S_COLLECT;
            MEM_ADDRESS <= BASE_BLOCK;
            remaining   <= (LENGTH == '0) ? FULL_LEN : {1'b0, LENGTH};
            byte_cnt    <= '0;
            idle_timer  <= '0;
            BYTE_READY  <= 1'b1;
            CPU_HOLD    <= 1'b1;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (byte_accept) begin
            MEM_WRITEDATA[{byte_cnt, 3'b000} +: 8] <= BYTE_DATA;
            idle_timer <= '0;
            byte_cnt   <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state      <= S_WRITE;
              BYTE_READY <= 1'b0;
              MEM_WRITE  <= 1'b1;
            end
          end else begin
            idle_timer <= idle_timer + TMR_W'(1);
            // partial block is simply abandoned; nothing is written
            if (idle_timer == TMR_W'(TIMEOUT - 1)) begin
              state      <= S_ERROR;
              BYTE_READY <= 1'b0;
              ERR        <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          // MEM_WRITE has already been high one full cycle at any edge here
          if (!MEM_BUSYWAIT) begin
            MEM_WRITE   <= 1'b0;
            MEM_ADDRESS <= MEM_ADDRESS + ADDR_W'(1);
            remaining   <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state    <= S_DONE;
              DONE     <= 1'b1;
              CPU_HOLD <= 1'b0;
            end else begin
              state      <= S_COLLECT;
              BYTE_READY <= 1'b1;
              byte_cnt   <= '0;
              idle_timer <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a BUSYWAIT memory model.
module tb_imem_loader;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TIMEOUT = 64;

  logic              CLK;
  logic              RESET;
  logic              START;
  logic [ADDR_W-1:0] BASE_BLOCK;
  logic [ADDR_W-1:0] LENGTH;
  logic              BYTE_VALID;
  logic [7:0]        BYTE_DATA;
  logic              BYTE_READY;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [127:0]      MEM_WRITEDATA;
  logic              MEM_BUSYWAIT;
  logic              CPU_HOLD;
  logic              DONE;
  logic              ERR;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .BASE_BLOCK(BASE_BLOCK), .LENGTH(LENGTH),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // memory model: busy for busy_len edges after MEM_WRITE rises
  int busy_len = 1;
  int busy_ctr = 0;
  assign MEM_BUSYWAIT = MEM_WRITE && (busy_ctr < busy_len);

  logic [ADDR_W-1:0] log_addr[$];
  logic [127:0]      log_data[$];
  int                log_cyc[$];
  int                hi_cnt    = 0;
  int                acc_cnt   = 0;
  int                stab_viol = 0;
  logic              prev_wr   = 1'b0;
  logic [ADDR_W-1:0] prev_a    = '0;
  logic [127:0]      prev_d    = '0;

  // observe handshakes, completed writes and write-phase stability
  always @(posedge CLK) begin
    busy_ctr <= MEM_WRITE ? busy_ctr + 1 : 0;
    if (BYTE_VALID && BYTE_READY) acc_cnt <= acc_cnt + 1;
    if (MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        log_addr.push_back(MEM_ADDRESS);
        log_data.push_back(MEM_WRITEDATA);
        log_cyc.push_back(hi_cnt + 1);
        hi_cnt <= 0;
      end else begin
        hi_cnt <= hi_cnt + 1;
      end
    end else begin
      hi_cnt <= 0;
    end
    if ((MEM_WRITE && prev_wr && (MEM_ADDRESS != prev_a || MEM_WRITEDATA != prev_d)) ||
        (MEM_WRITE && BYTE_READY))
      stab_viol <= stab_viol + 1;
    prev_wr <= MEM_WRITE;
    prev_a  <= MEM_ADDRESS;
    prev_d  <= MEM_WRITEDATA;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    START      = 1'b1;
    BASE_BLOCK = base;
    LENGTH     = len;
    @(negedge CLK);
    START      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    BYTE_VALID = 1'b1;
    BYTE_DATA  = b;
    while (!BYTE_READY && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) begin
      n_assert++;
      n_fail++;
      $error("FAIL byte_ready_wait: observed not ready expected ready within 200 cycles");
    end
    @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic send_byte_r(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge CLK);
    send_byte(b);
  endtask

  task automatic wait_write_end();
    int t = 0;
    while (MEM_WRITE && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("write_end_bound", 128'(MEM_WRITE), 128'(0));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!DONE && t < 500) begin
      @(negedge CLK);
      t++;
    end
    chk("done_bound", 128'(DONE), 128'(1));
  endtask

  function automatic logic [7:0] val(input int i, input int mult, input int off);
    return 8'(i * mult + off);
  endfunction

  function automatic logic [127:0] blk(input int j, input int mult, input int off);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = val(16 * j + k, mult, off);
    return d;
  endfunction

  initial begin
    int n0;
    int a0;
    int n;
    int seq_err;
    RESET      = 1'b1;
    START      = 1'b0;
    BASE_BLOCK = '0;
    LENGTH     = '0;
    BYTE_VALID = 1'b0;
    BYTE_DATA  = '0;
    repeat (2) @(negedge CLK);

    // reset state
    chk("rst_byte_ready", 128'(BYTE_READY), 128'(0));
    chk("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    chk("rst_mem_address", 128'(MEM_ADDRESS), 128'(0));
    chk("rst_mem_writedata", MEM_WRITEDATA, 128'(0));
    chk("rst_cpu_hold", 128'(CPU_HOLD), 128'(1));
    chk("rst_done", 128'(DONE), 128'(0));
    chk("rst_err", 128'(ERR), 128'(0));
    RESET = 1'b0;
    @(negedge CLK);

    // single block 0x00..0x0F to address 0
    busy_len = 3;
    n0 = log_addr.size();
    do_start(6'd0, 6'd1);
    chk("t1_ready_after_start", 128'(BYTE_READY), 128'(1));
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("t1_write_latency", 128'(MEM_WRITE), 128'(1));
    chk("t1_address", 128'(MEM_ADDRESS), 128'(0));
    chk("t1_data", MEM_WRITEDATA, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_cpu_hold_busy", 128'(CPU_HOLD), 128'(1));
    n = 0;
    while (MEM_WRITE && n < 50) begin
      chk("t1_ready_in_write", 128'(BYTE_READY), 128'(0));
      @(negedge CLK);
      n++;
    end
    chk("t1_done_same_edge", 128'(DONE), 128'(1));
    chk("t1_cpu_released", 128'(CPU_HOLD), 128'(0));
    chk("t1_write_count", 128'(log_addr.size() - n0), 128'(1));
    chk("t1_log_addr", 128'(log_addr[n0]), 128'(0));
    chk("t1_write_cycles", 128'(log_cyc[n0]), 128'(4));

    // three blocks wrapping 62,63,0 with 5-cycle busy
    busy_len = 5;
    n0 = log_addr.size();
    a0 = acc_cnt;
    do_start(6'd62, 6'd3);
    chk("t2_done_cleared", 128'(DONE), 128'(0));
    chk("t2_cpu_held", 128'(CPU_HOLD), 128'(1));
    for (int i = 0; i < 48; i++) send_byte(val(i, 7, 3));
    wait_done();
    chk("t2_write_count", 128'(log_addr.size() - n0), 128'(3));
    chk("t2_bytes", 128'(acc_cnt - a0), 128'(48));
    chk("t2_addr0", 128'(log_addr[n0]), 128'(62));
    chk("t2_addr1", 128'(log_addr[n0 + 1]), 128'(63));
    chk("t2_addr2", 128'(log_addr[n0 + 2]), 128'(0));
    for (int j = 0; j < 3; j++) begin
      chk("t2_data", log_data[n0 + j], blk(j, 7, 3));
      chk("t2_write_cycles", 128'(log_cyc[n0 + j]), 128'(6));
    end

    // randomly gapped valid
    busy_len = 2;
    n0 = log_addr.size();
    a0 = acc_cnt;
    do_start(6'd5, 6'd2);
    for (int i = 0; i < 32; i++) send_byte_r(val(i, 3, 8'hA0));
    wait_done();
    chk("t3_write_count", 128'(log_addr.size() - n0), 128'(2));
    chk("t3_bytes", 128'(acc_cnt - a0), 128'(32));
    chk("t3_addr0", 128'(log_addr[n0]), 128'(5));
    chk("t3_addr1", 128'(log_addr[n0 + 1]), 128'(6));
    chk("t3_data0", log_data[n0], blk(0, 3, 8'hA0));
    chk("t3_data1", log_data[n0 + 1], blk(1, 3, 8'hA0));

    // timeout after 10 bytes, then recovery
    n0 = log_addr.size();
    do_start(6'd10, 6'd1);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i));
    n = 0;
    while (!ERR && n < int'(TIMEOUT) + 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t4_timeout_cycles", 128'(n), 128'(TIMEOUT));
    chk("t4_err", 128'(ERR), 128'(1));
    chk("t4_cpu_hold", 128'(CPU_HOLD), 128'(1));
    chk("t4_ready_dropped", 128'(BYTE_READY), 128'(0));
    chk("t4_no_write", 128'(log_addr.size() - n0), 128'(0));
    do_start(6'd10, 6'd1);
    chk("t4_err_cleared", 128'(ERR), 128'(0));
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i));
    wait_done();
    chk("t4_err_after", 128'(ERR), 128'(0));
    chk("t4_write_count", 128'(log_addr.size() - n0), 128'(1));
    chk("t4_addr", 128'(log_addr[n0]), 128'(10));
    chk("t4_data", log_data[n0], 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

    // ignored START in COLLECT/WRITE, then reset during second write
    busy_len = 4;
    n0 = log_addr.size();
    do_start(6'd20, 6'd3);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    do_start(6'd40, 6'd1);
    for (int i = 5; i < 16; i++) send_byte(8'(i));
    chk("t5_addr_first", 128'(MEM_ADDRESS), 128'(20));
    do_start(6'd50, 6'd2);
    wait_write_end();
    chk("t5_not_done", 128'(DONE), 128'(0));
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    chk("t5_second_write", 128'(MEM_WRITE), 128'(1));
    chk("t5_addr_second", 128'(MEM_ADDRESS), 128'(21));
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("t5_rst_mem_write", 128'(MEM_WRITE), 128'(0));
    chk("t5_rst_cpu_hold", 128'(CPU_HOLD), 128'(1));
    chk("t5_rst_done", 128'(DONE), 128'(0));
    chk("t5_rst_addr", 128'(MEM_ADDRESS), 128'(0));
    @(negedge CLK);
    RESET = 1'b0;
    BYTE_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t5_idle_no_ready", 128'(BYTE_READY), 128'(0));
    BYTE_VALID = 1'b0;
    chk("t5_write_count", 128'(log_addr.size() - n0), 128'(1));

    // LENGTH=0 writes all 64 blocks
    busy_len = 0;
    n0 = log_addr.size();
    a0 = acc_cnt;
    do_start(6'd0, 6'd0);
    for (int i = 0; i < 1024; i++) send_byte(val(i, 5, 1));
    wait_done();
    chk("t6_write_count", 128'(log_addr.size() - n0), 128'(64));
    chk("t6_bytes", 128'(acc_cnt - a0), 128'(1024));
    seq_err = 0;
    for (int j = 0; j < 64 && n0 + j < log_addr.size(); j++)
      if (log_addr[n0 + j] != ADDR_W'(j)) seq_err++;
    chk("t6_addr_sequence", 128'(seq_err), 128'(0));
    chk("t6_data_first", log_data[n0], blk(0, 5, 1));
    chk("t6_data_last", log_data[n0 + 63], blk(63, 5, 1));
    chk("t6_cpu_released", 128'(CPU_HOLD), 128'(0));

    chk("write_hold_stable", 128'(stab_viol), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader and block writer for the instruction memory; it is the write-side counterpart of the instruction cache's block-read path.
- Accepts a byte stream over a valid/ready handshake and packs every 16 bytes into one 128-bit instruction block.
- Writes each block into instruction memory using the codebase's WRITE/ADDRESS/BUSYWAIT block protocol.
- Holds the CPU (CPU_HOLD, ORed into CPU reset at top level) until the whole program is in memory.

Parameters:
- ADDR_W, 6, block address width (64 blocks x 16 bytes = 1024 bytes).
- TIMEOUT, 1024, idle cycles allowed in COLLECT between accepted bytes before ERROR.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle load request; honoured only in IDLE, DONE or ERROR.
- BASE_BLOCK  input  ADDR_W  first block address; sampled on an accepted START.
- LENGTH  input  ADDR_W  number of blocks; 0 means 64; sampled on an accepted START.
- BYTE_VALID  input  1  byte stream valid.
- BYTE_DATA  input  8  byte stream data, lowest memory address first.
- BYTE_READY  output  1  loader can accept a byte.
- MEM_WRITE  output  1  block write request to instruction memory.
- MEM_ADDRESS  output  ADDR_W  block address.
- MEM_WRITEDATA  output  128  block data.
- MEM_BUSYWAIT  input  1  memory busy; rises combinationally on MEM_WRITE.
- CPU_HOLD  output  1  holds the CPU in reset.
- DONE  output  1  load complete.
- ERR  output  1  load aborted by timeout.

Behaviour:
- Reset values:
  - state=IDLE.
  - BYTE_READY=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - CPU_HOLD=1, DONE=0, ERR=0.
  - byte count=0, block count=0, idle timer=0.
- IDLE:
  - CPU_HOLD=1.
  - START -> COLLECT. Latch BASE_BLOCK into the address register. Latch LENGTH into remaining-block count (0 loads as 64).
- COLLECT:
  - BYTE_READY=1.
  - A byte is accepted at a posedge with BYTE_VALID&&BYTE_READY.
  - Byte k (0..15) of a block is placed at MEM_WRITEDATA[8k+7:8k].
  - Each accepted byte clears the idle timer; otherwise the timer increments.
  - On the 16th accepted byte -> WRITE on the next edge. BYTE_READY drops in the same cycle, so no 17th byte is taken.
  - Timer reaching TIMEOUT -> ERROR. The partial block is discarded and never written.
- WRITE:
  - MEM_WRITE=1; MEM_ADDRESS and MEM_WRITEDATA are held stable; BYTE_READY=0.
  - Completion is the first posedge, after at least one full cycle with MEM_WRITE high, at which MEM_BUSYWAIT=0. MEM_WRITE deasserts on that edge.
  - On completion: address increments modulo 2^ADDR_W (63 wraps to 0) and remaining count decrements.
  - If remaining becomes 0 -> DONE, otherwise -> COLLECT with byte count=0.
  - No timeout applies in WRITE; the loader waits on BUSYWAIT indefinitely.
- DONE:
  - DONE=1 and CPU_HOLD=0; both are registered and change on the same edge as entry to DONE.
  - START -> COLLECT: CPU_HOLD returns to 1 and DONE to 0 on that edge.
- ERROR:
  - ERR=1, CPU_HOLD=1.
  - START -> COLLECT with ERR cleared.
- START while in COLLECT or WRITE is ignored.
- BYTE_VALID outside COLLECT is ignored; nothing is accepted.
- RESET mid-operation:
  - Returns immediately to IDLE.
  - MEM_WRITE drops asynchronously; the in-flight write is abandoned.
  - CPU_HOLD=1.
- Latency:
  - Last byte to MEM_WRITE high: 1 cycle.
  - MEM_BUSYWAIT low to DONE (final block): 1 edge.

Test Plan:
- Reset, then START with BASE_BLOCK=0, LENGTH=1, and bytes 0x00..0x0F back to back -> one write to address 0. MEM_WRITEDATA=128'h0F0E..0100. DONE=1 and CPU_HOLD=0 after BUSYWAIT falls; BYTE_READY stays 0 during WRITE.
- LENGTH=3, BASE_BLOCK=62, memory BUSYWAIT held 5 cycles per write -> writes to addresses 62, 63, 0 in order. MEM_WRITE holds each block until BUSYWAIT drops; exactly 48 bytes accepted.
- BYTE_VALID toggled randomly during COLLECT -> only valid&&ready cycles are counted. Block contents match the accepted byte order; the 17th offered byte waits for the next COLLECT.
- Send 10 bytes, then stall for TIMEOUT cycles -> ERR=1, no MEM_WRITE, CPU_HOLD=1. A subsequent START plus a full block -> normal write and DONE, ERR=0.
- Assert RESET during WRITE of the second block -> MEM_WRITE=0 immediately, state IDLE, CPU_HOLD=1, DONE=0. START pulsed during COLLECT has no effect on the latched address or length.
- LENGTH=0 -> exactly 64 blocks written, then DONE.
